mod_exp_ctrl: RTL and testbench
===============================

// Module: mod_exp_ctrl
// PURPOSE
// Square-and-multiply modular exponentiation controller: result = base^exp mod modulus.
// Sits directly upstream of barrett_mult and drives its en/a/b/n inputs; consumes its r/valid outputs.
// Left-to-right binary method (MSB first). The core of the RSA encrypt datapath.
// PARAMETERS
// WIDTH  256  operand/modulus width; must equal the barrett_mult width
// EXP_W  256  exponent width
// CNT_W  $clog2(EXP_W)  bit-index counter width
// PORTS
// clk        in   1      clock, rising edge
// rst        in   1      synchronous reset, active-high
// start      in   1      1-cycle pulse; samples base/exp/modulus when idle
// base       in   WIDTH  message/base operand; must be < modulus
// exp        in   EXP_W  exponent
// modulus    in   WIDTH  modulus n
// result     out  WIDTH  base^exp mod modulus; held from done until next accepted start
// done       out  1      1-cycle pulse, result valid
// busy       out  1      high from the cycle after start is accepted through the done cycle
// err        out  1      sticky until next accepted start: modulus==0 or base>=modulus
// mul_en     out  1      1-cycle request pulse to barrett_mult
// mul_a      out  WIDTH  multiplier operand a
// mul_b      out  WIDTH  multiplier operand b
// mul_n      out  WIDTH  multiplier modulus (latched modulus)
// mul_r      in   WIDTH  multiplier result
// mul_valid  in   1      multiplier result strobe, 1 cycle
// BEHAVIOUR
// - Reset: state=IDLE; result=0; done=0; busy=0; err=0; mul_en=0; mul_a/mul_b/mul_n=0; acc=0; idx=0.
// - Reset mid-operation abandons the run; no done pulse. barrett_mult shares rst.
// - IDLE: on start, latch base/exp/modulus into internal registers. Clear err/result. Go to CHECK.
// - start while busy: ignored. Inputs need not stay stable after the accepting cycle.
// - CHECK (1 cycle):
//   - modulus==0 or base>=modulus: err=1, result=0 -> DONE.
//   - modulus==1: result=0 -> DONE.
//   - exp==0: result=1 -> DONE.
//   - otherwise: acc=1, idx=EXP_W-1 -> SCAN.
// - SCAN: 1 bit per cycle. While exp_r[idx]==0, decrement idx. At the first 1, go to SQ_REQ.
//   No multiplier use while scanning.
// - SQ_REQ: mul_a=mul_b=acc; mul_en=1 for exactly 1 cycle -> SQ_WAIT.
// - SQ_WAIT: hold mul_a/mul_b/mul_n stable. On mul_valid, acc<=mul_r.
//   - exp_r[idx]==1 -> MUL_REQ.
//   - exp_r[idx]==0 -> NEXT.
// - MUL_REQ: mul_a=acc, mul_b=base_r; mul_en=1 for 1 cycle -> MUL_WAIT.
// - MUL_WAIT: on mul_valid, acc<=mul_r -> NEXT.
// - NEXT:
//   - idx==0: result<=acc -> DONE.
//   - else: idx<=idx-1 -> SQ_REQ.
// - DONE: done=1 for 1 cycle; busy=1 in this cycle -> IDLE.
// - mul_valid outside SQ_WAIT/MUL_WAIT is ignored. mul_en is never asserted while a request is outstanding.
// - Op count for exp with highest set bit k and popcount p: (k+1) squares + p multiplies.
//   (The first square is 1*1, kept for uniformity.)
// - Each operation costs 1 REQ cycle + multiplier latency + 1 cycle.
// - Total latency = 2 (start accept + CHECK) + (EXP_W-1-k) SCAN cycles + 1 (SCAN exit)
//   + sum of the operation costs + 1 (DONE cycle).
// - Fast-exit cases: start -> done is exactly 3 cycles.
// - All arithmetic is delegated to barrett_mult. The only local logic is the compare base>=modulus
//   and the zero/one detection on modulus and exp.
// TESTING
// - base=7, exp=23, modulus=13 -> result=2, done pulse once, exactly 9 mul_en pulses (5 sq + 4 mul).
// - base=4, exp=13, modulus=497 -> result=445. base=96, exp=2, modulus=97 -> result=1.
// - exp=0, modulus=97 -> result=1. modulus=1 -> result=0. Both: no mul_en, done 3 cycles after start.
// - modulus=0 or base=100 with modulus=97 -> err=1, result=0, no mul_en. Next valid start clears err.
// - Assert rst during the 3rd MUL_WAIT of the 7^23 run -> busy/mul_en/done=0 the next cycle.
//   Then a fresh start gives result=2.
// - Pulse start again mid-run -> ignored, run completes with the original operands.
//   RSA-size vector: 256-bit base/modulus, exp=65537 -> matches the golden value from the software model.

Source files
------------

// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply modular exponentiation controller (result = base^exp mod modulus).
// Left-to-right binary method; all multiplies are delegated to an external barrett_mult.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           1-cycle pulse, samples base/exp/modulus when idle
//   base/exp/modulus operands (base must be < modulus)
//   result          base^exp mod modulus, held from done until next accepted start
//   done            1-cycle pulse, result valid
//   busy            high from the cycle after accept through the done cycle
//   err             sticky: modulus==0 or base>=modulus
//   mul_en/a/b/n    request to barrett_mult (a, b, modulus)
//   mul_r/mul_valid barrett_mult result and 1-cycle strobe
module mod_exp_ctrl #(
    parameter int WIDTH = 256,
    parameter int EXP_W = 256,
    parameter int CNT_W = $clog2(EXP_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic             mul_en,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_n,
    input  logic [WIDTH-1:0] mul_r,
    input  logic             mul_valid
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SCAN,
        S_SQ_REQ,
        S_SQ_WAIT,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] IDX_HI = CNT_W'(EXP_W - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_base;
    logic [EXP_W-1:0] r_exp;
    logic [WIDTH-1:0] r_mod;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_busy;
    logic             r_err;
    logic             r_mul_en;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;

    logic w_mod_zero;
    logic w_mod_one;
    logic w_base_ge;
    logic w_exp_zero;
    logic w_bit;

    assign w_mod_zero = (r_mod == '0);
    assign w_mod_one  = (r_mod == ONE);
    assign w_base_ge  = (r_base >= r_mod);
    assign w_exp_zero = (r_exp == '0);
    assign w_bit      = r_exp[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_mul_en <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The done pulse is shown here, one cycle after S_DONE;
                    // busy stays up with it so a start in that cycle is ignored.
                    if (r_done) begin
                        r_done <= 1'b0;
                        r_busy <= 1'b0;
                    end else if (start) begin
                        r_base   <= base;
                        r_exp    <= exp;
                        r_mod    <= modulus;
                        r_err    <= 1'b0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_mod_zero || w_base_ge) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                        r_state  <= S_DONE;
                    end else if (w_mod_one) begin
                        r_result <= '0;
                        r_state  <= S_DONE;
                    end else if (w_exp_zero) begin
                        r_result <= ONE;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc   <= ONE;
                        r_idx   <= IDX_HI;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // exp is known non-zero here, so the scan terminates.
                    if (w_bit) begin
                        r_state <= S_SQ_REQ;
                    end else begin
                        r_idx <= r_idx - CNT_W'(1);
                    end
                end
                S_SQ_REQ: begin
                    r_mul_en <= 1'b1;
                    r_mul_a  <= r_acc;
                    r_mul_b  <= r_acc;
                    r_state  <= S_SQ_WAIT;
                end
                S_SQ_WAIT: begin
                    r_mul_en <= 1'b0;
                    if (mul_valid) begin
                        r_acc   <= mul_r;
                        r_state <= w_bit ? S_MUL_REQ : S_NEXT;
                    end
                end
                S_MUL_REQ: begin
                    r_mul_en <= 1'b1;
                    r_mul_a  <= r_acc;
                    r_mul_b  <= r_base;
                    r_state  <= S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    r_mul_en <= 1'b0;
                    if (mul_valid) begin
                        r_acc   <= mul_r;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_idx == '0) begin
                        r_result <= r_acc;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - CNT_W'(1);
                        r_state <= S_SQ_REQ;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;
    assign err    = r_err;
    assign mul_en = r_mul_en;
    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign mul_n  = r_mod;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Testbench for mod_exp_ctrl with a behavioural fixed-latency multiplier.
// Directed vectors with hand-computed results plus one RSA-size vector.
module tb_mod_exp_ctrl;

    localparam int W     = 256;
    localparam int EW    = 256;
    localparam int LAT   = 3;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  base;
    logic [EW-1:0] exp;
    logic [W-1:0]  modulus;
    logic [W-1:0]  result;
    logic          done;
    logic          busy;
    logic          err;
    logic          mul_en;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_n;
    logic [W-1:0]  mul_r;
    logic          mul_valid;

    int passed = 0;
    int total  = 0;

    mod_exp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base(base), .exp(exp), .modulus(modulus),
        .result(result), .done(done), .busy(busy), .err(err),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
        .mul_r(mul_r), .mul_valid(mul_valid)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: r = a*b mod n after LAT cycles.
    logic         pend;
    int           cnt;
    logic [W-1:0] prod;
    logic [W-1:0] cap_a, cap_b, cap_n;
    logic         overlap_err = 1'b0;
    logic         hold_err    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            cnt       <= 0;
            mul_valid <= 1'b0;
            mul_r     <= '0;
        end else begin
            mul_valid <= 1'b0;
            if (mul_en) begin
                if (pend) overlap_err <= 1'b1;
                pend  <= 1'b1;
                cnt   <= LAT;
                cap_a <= mul_a;
                cap_b <= mul_b;
                cap_n <= mul_n;
                prod  <= W'(({{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b})
                           % {{W{1'b0}}, mul_n});
            end else if (pend) begin
                if (mul_a !== cap_a || mul_b !== cap_b || mul_n !== cap_n)
                    hold_err <= 1'b1;
                if (cnt == 1) begin
                    mul_valid <= 1'b1;
                    mul_r     <= prod;
                    pend      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    int en_cnt   = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (mul_en) en_cnt = en_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
    end

    function automatic logic [W-1:0] ref_modexp(
        input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
        logic [2*W-1:0] r, x, mm;
        mm = {{W{1'b0}}, m};
        r  = {{(2*W-1){1'b0}}, 1'b1} % mm;
        x  = {{W{1'b0}}, b} % mm;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[W-1:0];
    endfunction

    task automatic scramble();
        base    = {8{$urandom()}};
        exp     = {8{$urandom()}};
        modulus = {8{$urandom()}};
    endtask

    task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e,
                       input logic [W-1:0] m,
                       output logic [W-1:0] res, output int cyc);
        @(negedge clk);
        base = b; exp = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        cyc = 1;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= LIMIT) begin
            total++;
            $display("FAIL run_timeout: no done within %0d cycles", LIMIT);
        end
        res = result;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        base = '0; exp = '0; modulus = '0;
        repeat (3) @(negedge clk);
        total++;
        if (result !== '0) $display("FAIL reset_result got %0h want 0", result);
        else passed++;
        total++;
        if ({done, busy, err, mul_en} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {done, busy, err, mul_en});
        else passed++;
        total++;
        if ({mul_a, mul_b, mul_n} !== '0)
            $display("FAIL reset_mul_ops got nonzero want 0");
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] res;
        int cyc, e0, d0;
        e0 = en_cnt; d0 = done_cnt;
        run(W'(7), EW'(23), W'(13), res, cyc);
        repeat (2) @(negedge clk);
        total++;
        if (res !== W'(2)) $display("FAIL basic_result got %0d want 2", res);
        else passed++;
        total++;
        if (en_cnt - e0 !== 9) $display("FAIL basic_mul_count got %0d want 9", en_cnt - e0);
        else passed++;
        total++;
        if (done_cnt - d0 !== 1) $display("FAIL basic_done_count got %0d want 1", done_cnt - d0);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_vectors();
        logic [W-1:0] res;
        int cyc;
        run(W'(4), EW'(13), W'(497), res, cyc);
        total++;
        if (res !== W'(445)) $display("FAIL vec_4_13_497 got %0d want 445", res);
        else passed++;
        run(W'(96), EW'(2), W'(97), res, cyc);
        total++;
        if (res !== W'(1)) $display("FAIL vec_96_2_97 got %0d want 1", res);
        else passed++;
    endtask

    task automatic test_fast_exit();
        logic [W-1:0] res;
        int cyc, e0;
        e0 = en_cnt;
        run(W'(5), EW'(0), W'(97), res, cyc);
        total++;
        if (res !== W'(1)) $display("FAIL exp0_result got %0d want 1", res);
        else passed++;
        total++;
        if (cyc !== 3) $display("FAIL exp0_latency got %0d want 3", cyc);
        else passed++;
        run(W'(0), EW'(9), W'(1), res, cyc);
        total++;
        if (res !== W'(0)) $display("FAIL mod1_result got %0d want 0", res);
        else passed++;
        total++;
        if (cyc !== 3) $display("FAIL mod1_latency got %0d want 3", cyc);
        else passed++;
        total++;
        if (en_cnt !== e0) $display("FAIL fast_no_mul got %0d want 0", en_cnt - e0);
        else passed++;
    endtask

    task automatic test_err();
        logic [W-1:0] res;
        int cyc, e0;
        e0 = en_cnt;
        run(W'(3), EW'(5), W'(0), res, cyc);
        total++;
        if ({err, res} !== {1'b1, W'(0)})
            $display("FAIL err_mod0 got err=%b res=%0d want err=1 res=0", err, res);
        else passed++;
        run(W'(100), EW'(5), W'(97), res, cyc);
        repeat (3) @(negedge clk);
        total++;
        if ({err, res} !== {1'b1, W'(0)})
            $display("FAIL err_base_ge got err=%b res=%0d want err=1 res=0", err, res);
        else passed++;
        total++;
        if (en_cnt !== e0) $display("FAIL err_no_mul got %0d want 0", en_cnt - e0);
        else passed++;
        run(W'(7), EW'(23), W'(13), res, cyc);
        total++;
        if ({err, res} !== {1'b0, W'(2)})
            $display("FAIL err_cleared got err=%b res=%0d want err=0 res=2", err, res);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int cyc, e0, d0;
        e0 = en_cnt;
        @(negedge clk);
        base = W'(7); exp = EW'(23); modulus = W'(13); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        // 7th request is the 3rd multiply (bits 10111: S M S S M S M S M).
        while (en_cnt - e0 < 7 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc >= LIMIT) $display("FAIL rstmid_timeout: 7th request not seen");
        else passed++;
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, mul_en, done} !== 3'b0)
            $display("FAIL rstmid_flags got %b want 000", {busy, mul_en, done});
        else passed++;
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        total++;
        if (done_cnt !== d0) $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0);
        else passed++;
        run(W'(7), EW'(23), W'(13), res, cyc);
        total++;
        if (res !== W'(2)) $display("FAIL rstmid_rerun got %0d want 2", res);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc, d0;
        d0 = done_cnt;
        @(negedge clk);
        base = W'(7); exp = EW'(23); modulus = W'(13); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy);
        else passed++;
        base = W'(4); exp = EW'(13); modulus = W'(497); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (result !== W'(2)) $display("FAIL b2b_result got %0d want 2", result);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 1) $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_rsa();
        logic [W-1:0] b, m, res, want;
        int cyc;
        m = 256'hd5a8_2f31_7c4e_9b06_e1f3_5a27_c8d9_0b4f_3e62_a7d1_58c0_f94b_2d76_e83a_1c5f_9e07;
        b = 256'h4b1e_7a93_c2d5_06f8_91ab_3e4c_d760_2f18_a9b3_c45e_0d71_e28f_6a39_b5c4_07d2_e813;
        want = ref_modexp(b, EW'(65537), m);
        run(b, EW'(65537), m, res, cyc);
        total++;
        if (res !== want) $display("FAIL rsa_result got %h want %h", res, want);
        else passed++;
        total++;
        if ({overlap_err, hold_err} !== 2'b00)
            $display("FAIL mul_protocol got overlap=%b hold=%b want 0 0", overlap_err, hold_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_fast_exit();
        test_err();
        test_reset_mid();
        test_back_to_back();
        test_rsa();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
